vga_multi_ball: RTL

Parametrised VGA sprite generator: draws up to NUM_BALLS filled circles of programmable centre, radius and colour over a programmable background at 640x480/60 Hz from the 50 MHz system clock. It is an Avalon-MM slave on the lightweight bridge, like the single-ball peripheral it replaces. New behaviour:
- Per-ball registers are double-buffered and committed once per frame, so the image does not tear.
- Ball geometry uses true pixel coordinates.
- The pixel path is pipelined with sync-aligned outputs.
- A readable status word exposes frame count and vblank.

---
 rtl/vga_multi_ball.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_multi_ball.sv
// Multi-ball VGA sprite generator: Avalon-MM register file with per-frame commit of
// double-buffered ball state, plus a two-stage pixel pipeline with sync-aligned outputs.
module vga_multi_ball #(
    parameter int unsigned NUM_BALLS = 4,
    parameter int unsigned ADDR_W    = $clog2(4 * NUM_BALLS + 4),
    parameter int unsigned H_ACTIVE  = 1280,
    parameter int unsigned H_FP      = 32,
    parameter int unsigned H_SYNC    = 192,
    parameter int unsigned H_BP      = 96,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_CLK,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_n,
    output logic              VGA_SYNC_n
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned GBase  = 4 * NUM_BALLS;

    localparam logic [10:0] HLast      = 11'(HTotal - 1);
    localparam logic [10:0] HActive    = 11'(H_ACTIVE);
    localparam logic [10:0] HSyncStart = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HSyncEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VLast      = 10'(VTotal - 1);
    localparam logic [9:0]  VActive    = 10'(V_ACTIVE);
    localparam logic [9:0]  VCommit    = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  VSyncStart = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] r_hcount;
    logic [9:0]  r_vcount;

    // Shadow (bus-visible) and active (display) copies
    logic [9:0]  r_sx [NUM_BALLS];
    logic [9:0]  r_sy [NUM_BALLS];
    logic [7:0]  r_sr [NUM_BALLS];
    logic [23:0] r_sc [NUM_BALLS];
    logic [9:0]  r_ax [NUM_BALLS];
    logic [9:0]  r_ay [NUM_BALLS];
    logic [7:0]  r_ar [NUM_BALLS];
    logic [23:0] r_ac [NUM_BALLS];
    logic [23:0]          r_sbg, r_abg;
    logic [NUM_BALLS-1:0] r_sen, r_aen;
    logic [15:0]          r_frame;
    logic [31:0]          r_rdata;

    logic [10:0] r_dx [NUM_BALLS];
    logic [10:0] r_dy [NUM_BALLS];
    logic        r_blank1, r_hs1, r_vs1;
    logic [23:0] r_rgb;
    logic        r_blank2, r_hs2, r_vs2;

    logic                 w_commit, w_active, w_hs_n, w_vs_n, w_vblank, w_wr, w_rd;
    logic [31:0]          w_addr, w_rdata;
    logic [9:0]           w_px, w_py;
    logic [20:0]          w_dist [NUM_BALLS];
    logic [15:0]          w_r2 [NUM_BALLS];
    logic [NUM_BALLS-1:0] w_hit;
    logic [23:0]          w_rgb;
    logic                 w_unused;

    assign w_commit = (r_hcount == HLast) && (r_vcount == VCommit);
    assign w_active = (r_hcount < HActive) && (r_vcount < VActive);
    assign w_hs_n   = !((r_hcount >= HSyncStart) && (r_hcount < HSyncEnd));
    assign w_vs_n   = !((r_vcount >= VSyncStart) && (r_vcount < VSyncEnd));
    assign w_vblank = (r_vcount >= VActive);
    assign w_wr     = chipselect && write;
    assign w_rd     = chipselect && read;
    assign w_addr   = 32'(address);
    assign w_px     = r_hcount[10:1];
    assign w_py     = r_vcount;
    assign w_unused = ^writedata[31:24];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (r_hcount == HLast) begin
            r_hcount <= '0;
            r_vcount <= (r_vcount == VLast) ? '0 : r_vcount + 10'd1;
        end else begin
            r_hcount <= r_hcount + 11'd1;
        end
    end

    // A write on the commit cycle lands in shadow only; active takes the old shadow value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_BALLS); i++) begin
                r_sx[i] <= '0;
                r_sy[i] <= '0;
                r_sr[i] <= '0;
                r_sc[i] <= 24'hFFFFFF;
                r_ax[i] <= '0;
                r_ay[i] <= '0;
                r_ar[i] <= '0;
                r_ac[i] <= 24'hFFFFFF;
            end
            r_sbg   <= 24'h008000;
            r_abg   <= 24'h008000;
            r_sen   <= '0;
            r_aen   <= '0;
            r_frame <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_BALLS); i++) begin
                if (w_wr && w_addr == 32'(4 * i))     r_sx[i] <= writedata[9:0];
                if (w_wr && w_addr == 32'(4 * i + 1)) r_sy[i] <= writedata[9:0];
                if (w_wr && w_addr == 32'(4 * i + 2)) r_sr[i] <= writedata[7:0];
                if (w_wr && w_addr == 32'(4 * i + 3)) r_sc[i] <= writedata[23:0];
                if (w_commit) begin
                    r_ax[i] <= r_sx[i];
                    r_ay[i] <= r_sy[i];
                    r_ar[i] <= r_sr[i];
                    r_ac[i] <= r_sc[i];
                end
            end
            if (w_wr && w_addr == 32'(GBase))     r_sbg <= writedata[23:0];
            if (w_wr && w_addr == 32'(GBase + 1)) r_sen <= writedata[NUM_BALLS-1:0];
            if (w_commit) begin
                r_abg   <= r_sbg;
                r_aen   <= r_sen;
                r_frame <= r_frame + 16'd1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < int'(NUM_BALLS); i++) begin
            if (w_addr == 32'(4 * i))     w_rdata = {22'b0, r_sx[i]};
            if (w_addr == 32'(4 * i + 1)) w_rdata = {22'b0, r_sy[i]};
            if (w_addr == 32'(4 * i + 2)) w_rdata = {24'b0, r_sr[i]};
            if (w_addr == 32'(4 * i + 3)) w_rdata = {8'b0, r_sc[i]};
        end
        if (w_addr == 32'(GBase))     w_rdata = {8'b0, r_sbg};
        if (w_addr == 32'(GBase + 1)) w_rdata = 32'(r_sen);
        if (w_addr == 32'(GBase + 2)) w_rdata = {15'b0, w_vblank, r_frame};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rdata;
        end
    end

    // Stage 1: signed offsets from each centre, plus sync/blank alignment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_BALLS); i++) begin
                r_dx[i] <= '0;
                r_dy[i] <= '0;
            end
            r_blank1 <= 1'b0;
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
        end else begin
            for (int i = 0; i < int'(NUM_BALLS); i++) begin
                r_dx[i] <= {1'b0, w_px} - {1'b0, r_ax[i]};
                r_dy[i] <= {1'b0, w_py} - {1'b0, r_ay[i]};
            end
            r_blank1 <= w_active;
            r_hs1    <= w_hs_n;
            r_vs1    <= w_vs_n;
        end
    end

    // Offsets never reach -1024, so the magnitude fits in 10 bits
    function automatic logic [20:0] sq11(input logic [10:0] v);
        logic [9:0] mag;
        mag = v[10] ? 10'(-v) : v[9:0];
        return {11'b0, mag} * {11'b0, mag};
    endfunction

    always_comb begin
        for (int i = 0; i < int'(NUM_BALLS); i++) begin
            w_dist[i] = sq11(r_dx[i]) + sq11(r_dy[i]);
            w_r2[i]   = {8'b0, r_ar[i]} * {8'b0, r_ar[i]};
            w_hit[i]  = r_aen[i] && (w_dist[i] <= {5'b0, w_r2[i]});
        end
    end

    always_comb begin
        w_rgb = r_abg;
        for (int i = int'(NUM_BALLS) - 1; i >= 0; i--) begin
            if (w_hit[i]) w_rgb = r_ac[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb    <= '0;
            r_blank2 <= 1'b0;
            r_hs2    <= 1'b1;
            r_vs2    <= 1'b1;
        end else begin
            r_rgb    <= r_blank1 ? w_rgb : 24'h0;
            r_blank2 <= r_blank1;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
        end
    end

    assign readdata    = r_rdata;
    assign VGA_R       = r_rgb[23:16];
    assign VGA_G       = r_rgb[15:8];
    assign VGA_B       = r_rgb[7:0];
    assign VGA_CLK     = r_hcount[0];
    assign VGA_HS      = r_hs2;
    assign VGA_VS      = r_vs2;
    assign VGA_BLANK_n = r_blank2;
    assign VGA_SYNC_n  = 1'b0;

endmodule
